// File: rtl/motor_cmd_spi_rx_pkg.sv
// Shared types and constants for the motor command SPI receiver.
// Holds the per-motor command word, frame geometry and the duty clamp helper.
package motor_pkg;

    localparam logic [6:0] MAX_DUTY   = 7'd100;
    localparam int         FRAME_BITS = 16;

    typedef struct packed {
        logic       sign;
        logic [6:0] duty;
    } motor_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

    // A received byte carries sign in bit 7 and a duty that may exceed the PWM period.
    function automatic logic isOverLimit(input logic [7:0] rawByte);
        return rawByte[6:0] > MAX_DUTY;
    endfunction

    function automatic motor_cmd_t clampCmd(input logic [7:0] rawByte);
        motor_cmd_t cmd;
        cmd.sign = rawByte[7];
        cmd.duty = isOverLimit(rawByte) ? MAX_DUTY : rawByte[6:0];
        return cmd;
    endfunction

endpackage

// File: rtl/motor_cmd_spi_rx_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, with registered
// single-cycle rise/fall pulses taken against a third delayed copy.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
            r_fall <= ~r_sync & r_prev;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/motor_cmd_spi_rx.sv
// SPI mode-0 slave receiving two-byte motor commands, oversampled in the clk
// domain; clamps duties, echoes the applied command and enforces a watchdog.
module motor_cmd_spi_rx
    import motor_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4_800_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       sdi,
    input  logic       load,
    output logic       sdo,
    output logic       motor1_sign,
    output logic [6:0] motor1_upperlimit,
    output logic       motor2_sign,
    output logic [6:0] motor2_upperlimit,
    output logic       cmd_valid,
    output logic       frame_error,
    output logic       clamped,
    output logic       timeout
);

    localparam logic [4:0] C_FRAME_BITS = 5'(FRAME_BITS);
    localparam logic [4:0] C_COUNT_MAX  = 5'd31;

    logic w_sckLevelUnused;
    logic w_sckRise;
    logic w_sckFall;
    logic w_sdiSync;
    logic w_sdiRiseUnused;
    logic w_sdiFallUnused;
    logic w_loadSync;
    logic w_loadRise;
    logic w_loadFall;

    sync_edge u_syncSck (
        .clk    (clk),
        .reset  (reset),
        .i_async(sck),
        .o_sync (w_sckLevelUnused),
        .o_rise (w_sckRise),
        .o_fall (w_sckFall)
    );

    sync_edge u_syncSdi (
        .clk    (clk),
        .reset  (reset),
        .i_async(sdi),
        .o_sync (w_sdiSync),
        .o_rise (w_sdiRiseUnused),
        .o_fall (w_sdiFallUnused)
    );

    sync_edge u_syncLoad (
        .clk    (clk),
        .reset  (reset),
        .i_async(load),
        .o_sync (w_loadSync),
        .o_rise (w_loadRise),
        .o_fall (w_loadFall)
    );

    rx_state_t  r_state;
    rx_state_t  w_nextState;
    logic       r_startPending;
    logic [4:0] r_bitCount;
    logic [15:0] r_rx;
    logic [15:0] r_tx;
    logic       r_sdo;
    motor_cmd_t r_m1;
    motor_cmd_t r_m2;
    logic       r_cmdValid;
    logic       r_frameError;
    logic       r_clamped;
    logic       r_timeout;
    logic [23:0] r_wdCount;

    logic       w_start;
    logic       w_frameOk;
    logic       w_frameBad;
    motor_cmd_t w_new1;
    motor_cmd_t w_new2;
    logic       w_anyClamp;

    // A load rise seen during CHECK is remembered so IDLE can still start that frame.
    assign w_start    = (r_state == IDLE) && (w_loadRise || (r_startPending && w_loadSync));
    assign w_frameOk  = (r_state == CHECK) && (r_bitCount == C_FRAME_BITS);
    assign w_frameBad = (r_state == CHECK) && (r_bitCount != C_FRAME_BITS);
    assign w_new1     = clampCmd(r_rx[15:8]);
    assign w_new2     = clampCmd(r_rx[7:0]);
    assign w_anyClamp = isOverLimit(r_rx[15:8]) || isOverLimit(r_rx[7:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_start) w_nextState = SHIFT;
            SHIFT:   if (w_loadFall) w_nextState = CHECK;
            CHECK:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Shift path: rx captures on sck rise, tx presents the next echo bit on sck fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_startPending <= 1'b0;
            r_bitCount     <= 5'd0;
            r_rx           <= 16'd0;
            r_tx           <= 16'd0;
            r_sdo          <= 1'b0;
        end else begin
            if (r_state == CHECK && w_loadRise) begin
                r_startPending <= 1'b1;
            end else if (r_state == IDLE) begin
                r_startPending <= 1'b0;
            end

            if (w_start) begin
                r_bitCount <= 5'd0;
                r_tx       <= {r_m1, r_m2};
                r_sdo      <= r_m1.sign;
            end else if (r_state == SHIFT) begin
                if (w_sckRise) begin
                    r_rx <= {r_rx[14:0], w_sdiSync};
                    if (r_bitCount != C_COUNT_MAX) begin
                        r_bitCount <= r_bitCount + 5'd1;
                    end
                end
                if (w_sckFall) begin
                    r_tx  <= {r_tx[14:0], 1'b0};
                    r_sdo <= r_tx[14];
                end
            end
        end
    end

    // A valid frame takes priority over watchdog expiry in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m1         <= '0;
            r_m2         <= '0;
            r_cmdValid   <= 1'b0;
            r_frameError <= 1'b0;
            r_clamped    <= 1'b0;
            r_timeout    <= 1'b0;
            r_wdCount    <= 24'd0;
        end else begin
            r_cmdValid   <= 1'b0;
            r_frameError <= 1'b0;
            if (w_frameOk) begin
                r_m1       <= w_new1;
                r_m2       <= w_new2;
                r_cmdValid <= 1'b1;
                r_wdCount  <= 24'd0;
                r_timeout  <= 1'b0;
                if (w_anyClamp) begin
                    r_clamped <= 1'b1;
                end
            end else begin
                if (w_frameBad) begin
                    r_frameError <= 1'b1;
                end
                if (r_wdCount != TIMEOUT_CYCLES) begin
                    r_wdCount <= r_wdCount + 24'd1;
                end
                if (r_wdCount == TIMEOUT_CYCLES - 24'd1) begin
                    r_timeout  <= 1'b1;
                    r_m1.duty  <= 7'd0;
                    r_m2.duty  <= 7'd0;
                end
            end
        end
    end

    assign sdo               = r_sdo;
    assign motor1_sign       = r_m1.sign;
    assign motor1_upperlimit = r_m1.duty;
    assign motor2_sign       = r_m2.sign;
    assign motor2_upperlimit = r_m2.duty;
    assign cmd_valid         = r_cmdValid;
    assign frame_error       = r_frameError;
    assign clamped           = r_clamped;
    assign timeout           = r_timeout;

endmodule

// File: tb/tb_motor_cmd_spi_rx.sv
// Randomised scoreboard bench for motor_cmd_spi_rx: frames are driven as an MCU
// would, expected results queued from a byte-level model, and checked by a monitor.
module tb_motor_cmd_spi_rx;

    localparam int T_CYCLES = 1000;
    localparam int HALF     = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       sck;
    logic       sdi;
    logic       load;
    logic       sdo;
    logic       motor1_sign;
    logic [6:0] motor1_upperlimit;
    logic       motor2_sign;
    logic [6:0] motor2_upperlimit;
    logic       cmd_valid;
    logic       frame_error;
    logic       clamped;
    logic       timeout;

    motor_cmd_spi_rx #(.TIMEOUT_CYCLES(24'd1000)) dut (
        .clk              (clk),
        .reset            (reset),
        .sck              (sck),
        .sdi              (sdi),
        .load             (load),
        .sdo              (sdo),
        .motor1_sign      (motor1_sign),
        .motor1_upperlimit(motor1_upperlimit),
        .motor2_sign      (motor2_sign),
        .motor2_upperlimit(motor2_upperlimit),
        .cmd_valid        (cmd_valid),
        .frame_error      (frame_error),
        .clamped          (clamped),
        .timeout          (timeout)
    );

    always #5 clk = ~clk;

    int cycleCount = 0;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    typedef struct {
        bit isError;
        bit s1;
        int d1;
        bit s2;
        int d2;
        bit clampedExp;
        bit timeoutExp;
        int expCycle;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   checks = 0;
    int   failures = 0;
    int   lastValidCycle = 0;

    bit modelS1 = 0;
    int modelD1 = 0;
    bit modelS2 = 0;
    int modelD2 = 0;
    bit modelClamped = 0;
    bit modelTimeout = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Monitor: every cmd_valid/frame_error cycle consumes one queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && (cmd_valid === 1'b1 || frame_error === 1'b1)) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_event actual cmd_valid=%0b frame_error=%0b required none",
                         cmd_valid, frame_error);
            end else begin
                monE = expQ.pop_front();
                checkOutput("event_kind", {30'd0, cmd_valid, frame_error}, monE.isError ? 32'd1 : 32'd2);
                checkOutput("event_latency", cycleCount, monE.expCycle);
                checkOutput("m1_sign", motor1_sign, monE.s1);
                checkOutput("m1_duty", motor1_upperlimit, monE.d1);
                checkOutput("m2_sign", motor2_sign, monE.s2);
                checkOutput("m2_duty", motor2_upperlimit, monE.d2);
                checkOutput("clamped", clamped, monE.clampedExp);
                checkOutput("timeout_at_event", timeout, monE.timeoutExp);
                if (!monE.isError) lastValidCycle = cycleCount;
            end
        end
    end

    task automatic applyStimulus(input int nbits, input logic [31:0] data);
        exp_t        e;
        logic [15:0] echo;
        logic [15:0] expEcho;
        int          b1;
        int          b2;
        int          k;
        echo    = 16'd0;
        expEcho = {modelS1, 7'(modelD1), modelS2, 7'(modelD2)};
        @(posedge clk); #1;
        sck  = 1'b0;
        load = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi = data[i];
            repeat (HALF) @(posedge clk);
            #1;
            k = nbits - 1 - i;
            if (k < 16) echo[15 - k] = sdo;
            sck = 1'b1;
            repeat (HALF) @(posedge clk);
            #1;
            sck = 1'b0;
        end
        repeat (HALF) @(posedge clk);
        #1;
        if (nbits >= 16) checkOutput("sdo_echo", echo, expEcho);
        if (nbits == 16) begin
            b1 = int'(data[15:8]);
            b2 = int'(data[7:0]);
            modelS1 = (b1 / 128) != 0;
            modelD1 = b1 % 128;
            modelS2 = (b2 / 128) != 0;
            modelD2 = b2 % 128;
            if (modelD1 > 100) begin modelD1 = 100; modelClamped = 1; end
            if (modelD2 > 100) begin modelD2 = 100; modelClamped = 1; end
            modelTimeout = 0;
        end
        e.isError    = (nbits != 16);
        e.s1         = modelS1;
        e.d1         = modelD1;
        e.s2         = modelS2;
        e.d2         = modelD2;
        e.clampedExp = modelClamped;
        e.timeoutExp = modelTimeout;
        e.expCycle   = cycleCount + 5;
        expQ.push_back(e);
        load = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("event_seen", expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_m1_sign"}, motor1_sign, 0);
        checkOutput({tag, "_m1_duty"}, motor1_upperlimit, 0);
        checkOutput({tag, "_m2_sign"}, motor2_sign, 0);
        checkOutput({tag, "_m2_duty"}, motor2_upperlimit, 0);
        checkOutput({tag, "_clamped"}, clamped, 0);
        checkOutput({tag, "_timeout"}, timeout, 0);
        checkOutput({tag, "_sdo"}, sdo, 0);
        checkOutput({tag, "_pulses"}, {cmd_valid, frame_error}, 0);
    endtask

    initial begin
        int target;
        bit prevValid;
        reset = 1'b1;
        sck   = 1'b0;
        sdi   = 1'b0;
        load  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkIdleOutputs("in_reset");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("after_reset");

        applyStimulus(16, 32'h8A32);
        applyStimulus(16, 32'h7FE5);
        applyStimulus(16, 32'h1234);
        applyStimulus(15, $urandom);
        applyStimulus(17, $urandom);
        applyStimulus(16, 32'h8A32);
        applyStimulus(16, $urandom);

        prevValid = 1;
        for (int n = 0; n < 10; n++) begin
            int len;
            int pick;
            len = 16;
            if (prevValid && $urandom_range(0, 2) == 0) begin
                pick = $urandom_range(0, 3);
                len  = (pick == 0) ? 0 : (pick == 1) ? 8 : (pick == 2) ? 15 : 17;
            end
            applyStimulus(len, $urandom);
            prevValid = (len == 16);
        end

        applyStimulus(16, 32'hC5B7);
        target = lastValidCycle + T_CYCLES - 2;
        while (cycleCount < target) @(negedge clk);
        checkOutput("wd_before_timeout", timeout, 0);
        checkOutput("wd_before_m1_duty", motor1_upperlimit, modelD1);
        target = lastValidCycle + T_CYCLES + 2;
        while (cycleCount < target) @(negedge clk);
        checkOutput("wd_expired_timeout", timeout, 1);
        checkOutput("wd_expired_m1_duty", motor1_upperlimit, 0);
        checkOutput("wd_expired_m2_duty", motor2_upperlimit, 0);
        checkOutput("wd_expired_m1_sign", motor1_sign, modelS1);
        checkOutput("wd_expired_m2_sign", motor2_sign, modelS2);
        modelD1 = 0;
        modelD2 = 0;
        modelTimeout = 1;
        applyStimulus(16, 32'h2A9E);
        checkOutput("wd_recovered_timeout", timeout, 0);

        @(posedge clk); #1;
        load = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            sdi = 1'($urandom_range(0, 1));
            repeat (HALF) @(posedge clk);
            #1;
            sck = 1'b1;
            repeat (HALF) @(posedge clk);
            #1;
            sck = 1'b0;
        end
        reset = 1'b1;
        load  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkIdleOutputs("midframe_reset");
        reset = 1'b0;
        modelS1 = 0; modelD1 = 0; modelS2 = 0; modelD2 = 0;
        modelClamped = 0;
        modelTimeout = 0;
        repeat (6) @(posedge clk);
        #1;
        checkIdleOutputs("post_midframe_reset");
        applyStimulus(16, 32'h0505);

        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/motor_cmd_spi_rx.md
Name: motor_cmd_spi_rx

Overview:
SPI slave that receives per-frame motor commands from the MCU and produces the held sign/duty inputs consumed by the H-bridge PWM block (motor1_sign, motor1_upperlimit, motor2_sign, motor2_upperlimit).
- Oversamples SPI in the clk domain.
- Validates frame length and clamps duty to the PWM period.
- Echoes the currently applied command back on sdo.
- A watchdog forces duty to 0 if the MCU stops sending, so the robot coasts safely.

Parameters:
MAX_DUTY, 7'd100, largest legal duty; equals PWM counter period.
FRAME_BITS, 16, bits per valid frame (2 bytes).
TIMEOUT_CYCLES, 24'd4_800_000, clk cycles without a valid frame before duties are forced to 0 (100 ms at 48 MHz).

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
sck  input  1  SPI clock from MCU (async to clk); mode 0.
sdi  input  1  SPI data MCU->FPGA; MSB first.
load  input  1  frame strobe from MCU; high for the whole frame (async).
sdo  output  1  SPI data FPGA->MCU; echo of applied command.
motor1_sign  output  1  direction, motor 1.
motor1_upperlimit  output  7  duty, motor 1, 0..MAX_DUTY.
motor2_sign  output  1  direction, motor 2.
motor2_upperlimit  output  7  duty, motor 2, 0..MAX_DUTY.
cmd_valid  output  1  one-cycle pulse when a new command is applied.
frame_error  output  1  one-cycle pulse on a bad-length frame.
clamped  output  1  sticky; set when any duty was clamped; cleared by reset.
timeout  output  1  high while watchdog has expired.

Behaviour:
- Reset (sync, active-high): all motor outputs 0, cmd_valid/frame_error/clamped/timeout 0, sdo 0, bit counter 0, shift registers 0, watchdog counter 0, FSM IDLE.
- Synchronisers: sck, sdi and load each pass through a 2-flop synchroniser. Edges are detected against a third registered copy. Requires clk ≥ 8× sck.
- FSM has three states:
  - IDLE -> SHIFT on synced load rise.
  - SHIFT -> CHECK on synced load fall.
  - CHECK -> IDLE unconditionally, after one cycle.
- On load rise:
  - bit count cleared.
  - tx shift register loaded with {motor1_sign, motor1_upperlimit, motor2_sign, motor2_upperlimit}.
  - sdo = tx[15] from the next cycle.
- SHIFT:
  - On synced sck rise: rx <= {rx[14:0], sdi_sync}; bit count +1, saturating at 31.
  - On synced sck fall: tx shifts left, and sdo = new tx[15].
- CHECK, bit count == FRAME_BITS:
  - byte0 = rx[15:8] -> motor1: sign = bit7, duty = bits6:0.
  - byte1 = rx[7:0] -> motor2, same mapping.
  - Any duty > MAX_DUTY is replaced by MAX_DUTY and sets clamped.
  - Outputs update and cmd_valid pulses in the same cycle.
  - Watchdog counter cleared; timeout deasserted.
- CHECK, bit count != FRAME_BITS (including 0): frame_error pulses and motor outputs are unchanged.
- Latency: cmd_valid is 4 clk cycles after the first rising clk edge that samples load low (2 synchroniser stages + edge register + CHECK).
- Watchdog:
  - Counts every cycle, saturating at TIMEOUT_CYCLES.
  - On reaching it: timeout=1 and both upperlimit outputs forced to 0; signs are held.
  - The next valid frame restores normal operation.
- Simultaneous events:
  - A valid frame in the same cycle as watchdog expiry wins; outputs take the new command and timeout stays 0.
  - sck edges while in IDLE or CHECK are ignored.
  - A load rise during CHECK is handled on return to IDLE, because the synced load level is rechecked there.
- Reset mid-frame: the partial frame is discarded; the next frame needs a fresh load rise.

Decomposition:
- Package motor_pkg holds:
  - typedef motor_cmd_t = struct packed {logic sign; logic [6:0] duty;}.
  - MAX_DUTY and FRAME_BITS constants.
  - FSM state enum {IDLE, SHIFT, CHECK}.
- Sub-module sync_edge: 2-flop synchroniser plus rise/fall pulse outputs. Instantiated 3× (sck, sdi, load); the edge outputs are unused for sdi.

Test Plan:
1. Reset, then frame 0x8A_32 (16 bits, sck = clk/8) -> cmd_valid once 4 cycles after load low; motor1 sign=1 duty=10; motor2 sign=0 duty=50; clamped=0.
2. Frame 0x7F_E5 -> motor1 duty=100 (clamped from 127), motor2 sign=1 duty=100 (from 101); clamped=1 and stays 1 after a later legal frame.
3. Frame of 15 bits, then one of 17 bits -> frame_error pulse each time; outputs keep the previous values; no cmd_valid.
4. After applying 0x8A_32, send any frame and capture sdo on sck rise -> MCU reads 0x8A32; outputs become the new command.
5. TIMEOUT_CYCLES=1000; no frames for 1000 cycles after a valid frame -> timeout=1, both duties 0, signs held; next valid frame -> timeout=0 with new duties.
6. Assert reset after 8 bits of a frame, release, send full 0x0505 -> outputs 0 during and after reset; then duties 5/5 with one cmd_valid.
